// File: rtl/idct_mac_sched.sv
// Row sequencer for the IDCT: buffers N samples, then time-shares one external
// shift-add multiplier over all N*N sample/coefficient pairs, emitting y[k] per row.
module idct_mac_sched #(
    parameter  int N     = 8,
    parameter  int ACC_W = 16 + $clog2(N),
    localparam int LN    = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic [2*LN-1:0]   coef_addr,
    input  logic [7:0]        coef_data,
    output logic [7:0]        mul_data,
    output logic [7:0]        mul_coef,
    input  logic [15:0]       mul_prod,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic [LN-1:0]     m_index,
    output logic              busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [LN-1:0]    cnt, cnt_nx;
    logic [LN-1:0]    k, k_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [7:0]       sbuf [N];
    logic             accept;

    assign accept = s_valid & s_ready;

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        k_nx     = k;
        acc_nx   = acc;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (cnt == LN'(N - 1)) begin
                        cnt_nx   = '0;
                        k_nx     = '0;
                        state_nx = MAC;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            MAC: begin
                // First product of a dot product restarts the sum; wraps modulo 2^ACC_W.
                acc_nx = (cnt == '0 ? '0 : acc) + {{(ACC_W-16){mul_prod[15]}}, mul_prod};
                if (cnt == LN'(N - 1)) begin
                    cnt_nx   = '0;
                    state_nx = OUT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    if (k == LN'(N - 1)) begin
                        k_nx     = '0;
                        state_nx = LOAD;
                    end else begin
                        k_nx     = k + 1'b1;
                        state_nx = MAC;
                    end
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            k     <= k_nx;
            acc   <= acc_nx;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; it is fully rewritten
    // in LOAD before any read, and a reset would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (accept) sbuf[cnt] <= s_data;
    end

    // Outputs decode the state, and rst forces them to zero within its own cycle.
    always_comb begin
        s_ready   = (state == LOAD) && !rst;
        busy      = (state == MAC || state == OUT) && !rst;
        m_valid   = (state == OUT) && !rst;
        m_data    = '0;
        m_index   = '0;
        coef_addr = '0;
        mul_data  = '0;
        mul_coef  = '0;
        if (!rst && state == MAC) begin
            coef_addr = {k, cnt};
            mul_data  = sbuf[cnt];
            mul_coef  = coef_data;
        end
        if (!rst && state == OUT) begin
            m_data  = acc;
            m_index = k;
        end
    end

endmodule
